// File: rtl/lcd_char_sequencer.sv
// Avalon-MM master for the 16207 character LCD slave: runs the HD44780 power-up
// init, then turns a valid/ready byte stream into timed command/data writes.
module lcd_char_sequencer #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int E_PULSE_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [1:0] av_address,
  output logic       av_write,
  output logic       av_read,
  output logic       av_begintransfer,
  output logic [7:0] av_writedata,
  output logic       init_done,
  output logic       busy
);

  localparam int M0 = (POWERUP_CYCLES > E_PULSE_CYCLES) ? POWERUP_CYCLES : E_PULSE_CYCLES;
  localparam int M1 = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int MAXP = (M0 > M1) ? M0 : M1;
  localparam int CW = $clog2(MAXP + 1);

  typedef enum logic [2:0] {PWR_WAIT, SETUP, STROBE, HOLD, WAIT, IDLE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    addr, addr_nx;
  logic [7:0]    data, data_nx;
  logic          line, line_nx;
  logic [3:0]    col, col_nx;
  logic          pend, pend_nx;
  logic [7:0]    pend_data, pend_data_nx;
  logic [2:0]    init_idx, init_idx_nx;
  logic          done, done_nx;
  logic [CW-1:0] wait_last;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
      3'd3:             init_cmd = 8'h0C;
      3'd4:             init_cmd = 8'h01;
      default:          init_cmd = 8'h06;
    endcase
  endfunction

  // Clear and home need the long controller busy time.
  assign wait_last = (addr == 2'b00 && (data == 8'h01 || data == 8'h02)) ?
                     CW'(CLEAR_WAIT_CYCLES - 1) : CW'(CMD_WAIT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      addr      <= 2'b00;
      data      <= 8'h00;
      line      <= 1'b0;
      col       <= 4'd0;
      pend      <= 1'b0;
      pend_data <= 8'h00;
      init_idx  <= 3'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      addr      <= addr_nx;
      data      <= data_nx;
      line      <= line_nx;
      col       <= col_nx;
      pend      <= pend_nx;
      pend_data <= pend_data_nx;
      init_idx  <= init_idx_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + 1'b1;
    addr_nx      = addr;
    data_nx      = data;
    line_nx      = line;
    col_nx       = col;
    pend_nx      = pend;
    pend_data_nx = pend_data;
    init_idx_nx  = init_idx;
    done_nx      = done;
    case (state)
      PWR_WAIT: if (cnt == CW'(POWERUP_CYCLES - 1)) begin
        state_nx    = SETUP;
        cnt_nx      = '0;
        addr_nx     = 2'b00;
        data_nx     = init_cmd(3'd0);
        init_idx_nx = 3'd0;
      end
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = '0;
      end
      STROBE: if (cnt == CW'(E_PULSE_CYCLES - 1)) begin
        state_nx = HOLD;
        cnt_nx   = '0;
      end
      HOLD: begin
        state_nx = WAIT;
        cnt_nx   = '0;
      end
      WAIT: if (cnt == wait_last) begin
        cnt_nx = '0;
        if (!done) begin
          if (init_idx == 3'd5) begin
            done_nx  = 1'b1;
            line_nx  = 1'b0;
            col_nx   = 4'd0;
            state_nx = IDLE;
          end else begin
            init_idx_nx = init_idx + 3'd1;
            addr_nx     = 2'b00;
            data_nx     = init_cmd(init_idx + 3'd1);
            state_nx    = SETUP;
          end
        end else if (pend) begin
          pend_nx  = 1'b0;
          addr_nx  = 2'b00;
          data_nx  = pend_data;
          state_nx = SETUP;
        end else begin
          state_nx = IDLE;
        end
      end
      IDLE: begin
        cnt_nx = '0;
        if (in_valid && done) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            state_nx = SETUP;
            addr_nx  = 2'b10;
            data_nx  = in_data;
            // Column 16 is off-screen: queue the cursor move to the other line.
            if (col == 4'd15) begin
              pend_nx      = 1'b1;
              pend_data_nx = line ? 8'h80 : 8'hC0;
              line_nx      = ~line;
              col_nx       = 4'd0;
            end else begin
              col_nx = col + 4'd1;
            end
          end else begin
            case (in_data)
              8'h0A: begin
                state_nx = SETUP;
                addr_nx  = 2'b00;
                data_nx  = line ? 8'h80 : 8'hC0;
                line_nx  = ~line;
                col_nx   = 4'd0;
              end
              8'h0C: begin
                state_nx = SETUP;
                addr_nx  = 2'b00;
                data_nx  = 8'h01;
                line_nx  = 1'b0;
                col_nx   = 4'd0;
              end
              8'h0D: begin
                state_nx = SETUP;
                addr_nx  = 2'b00;
                data_nx  = line ? 8'hC0 : 8'h80;
                col_nx   = 4'd0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_nx = PWR_WAIT;
    endcase
  end

  assign av_write         = (state == STROBE);
  assign av_begintransfer = (state == STROBE) && (cnt == '0);
  assign av_read          = 1'b0;
  assign av_address       = addr;
  assign av_writedata     = data;
  assign init_done        = done;
  assign in_ready         = (state == IDLE) && done;
  assign busy             = ~in_ready;

endmodule

// File: tb/tb_lcd_char_sequencer.sv
// Directed bench for lcd_char_sequencer with shortened timing parameters.
module tb_lcd_char_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [1:0] av_address;
  logic       av_write;
  logic       av_read;
  logic       av_begintransfer;
  logic [7:0] av_writedata;
  logic       init_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lcd_char_sequencer #(
    .POWERUP_CYCLES(20), .E_PULSE_CYCLES(3), .CMD_WAIT_CYCLES(5), .CLEAR_WAIT_CYCLES(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .av_address(av_address), .av_write(av_write), .av_read(av_read),
    .av_begintransfer(av_begintransfer), .av_writedata(av_writedata),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Waits for (or finds already active) one av_write pulse, checks it, then
  // counts cycles until the next pulse or in_ready.
  task automatic exp_xfer(input string tag, input logic [1:0] a, input logic [7:0] d,
                          input int gap, output int lat);
    int n;
    int w;
    n = 0;
    while (!av_write && n < 400) begin @(posedge clk); #1; n++; end
    lat = n;
    if (!av_write) begin
      chk({tag, " timeout"}, 0, 1);
      return;
    end
    chk({tag, " addr"}, av_address, a);
    chk({tag, " data"}, av_writedata, d);
    chk({tag, " begin"}, av_begintransfer, 1);
    w = 1;
    forever begin
      @(posedge clk); #1;
      if (!av_write || w > 50) break;
      w++;
      chk({tag, " strobe"}, {av_begintransfer, av_address, av_writedata}, {1'b0, a, d});
    end
    chk({tag, " width"}, w, 3);
    chk({tag, " hold"}, {av_address, av_writedata}, {a, d});
    n = 0;
    while (!av_write && !in_ready && n < 400) begin @(posedge clk); #1; n++; end
    chk({tag, " gap"}, n, gap);
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send timeout", 0, 1);
  endtask

  task automatic run_init();
    int lat;
    reset_n = 1'b1;
    exp_xfer("i0", 2'b00, 8'h38, 7, lat);
    chk("powerup latency", lat, 21);
    chk("init_done early", init_done, 0);
    exp_xfer("i1", 2'b00, 8'h38, 7, lat);
    exp_xfer("i2", 2'b00, 8'h38, 7, lat);
    exp_xfer("i3", 2'b00, 8'h0C, 7, lat);
    exp_xfer("i4", 2'b00, 8'h01, 12, lat);
    exp_xfer("i5", 2'b00, 8'h06, 6, lat);
    chk("init_done", init_done, 1);
    chk("ready after init", in_ready, 1);
  endtask

  initial begin
    int lat;
    int t0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst write", av_write, 0);
    chk("rst addr", av_address, 0);
    chk("rst data", av_writedata, 0);
    chk("rst ready", in_ready, 0);
    chk("rst done", init_done, 0);
    chk("rst read", av_read, 0);

    run_init();

    send(8'h41, 1'b0);
    t0 = cyc;
    exp_xfer("A", 2'b10, 8'h41, 6, lat);
    chk("A busy len", cyc - t0, 10);

    send(8'h0D, 1'b0);
    exp_xfer("cr0", 2'b00, 8'h80, 6, lat);
    for (int i = 0; i < 16; i++) begin
      send(8'h30, 1'b0);
      exp_xfer("row0", 2'b10, 8'h30, (i == 15) ? 7 : 6, lat);
    end
    exp_xfer("wrap1", 2'b00, 8'hC0, 6, lat);
    for (int i = 0; i < 16; i++) begin
      send(8'h30, 1'b0);
      exp_xfer("row1", 2'b10, 8'h30, (i == 15) ? 7 : 6, lat);
    end
    exp_xfer("wrap0", 2'b00, 8'h80, 6, lat);

    send(8'h0C, 1'b0);
    exp_xfer("clr", 2'b00, 8'h01, 11, lat);
    send(8'h42, 1'b0);
    exp_xfer("B", 2'b10, 8'h42, 6, lat);
    send(8'h0A, 1'b0);
    exp_xfer("lf", 2'b00, 8'hC0, 6, lat);
    send(8'h0D, 1'b0);
    exp_xfer("cr1", 2'b00, 8'hC0, 6, lat);

    send(8'h07, 1'b1);
    chk("ctl ready", in_ready, 1);
    chk("ctl nowrite", av_write, 0);
    in_data = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("D accepted", in_ready, 0);
    exp_xfer("D", 2'b10, 8'h44, 6, lat);

    send(8'h45, 1'b0);
    @(posedge clk); #1;
    chk("E strobe1", av_write, 1);
    @(posedge clk); #1;
    chk("E strobe2", av_write, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid rst write", av_write, 0);
    chk("mid rst done", init_done, 0);
    chk("mid rst addr", av_address, 0);
    chk("mid rst ready", in_ready, 0);
    @(posedge clk); #1;
    run_init();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
